alu_control_mdu: RTL
====================

Name: alu_control_mdu

Overview:
Parametrised successor to the single-cycle ALU control decoder. It keeps the ALUOp/funct to 4-bit ALU_control decode and adds XOR. It also adds a multi-cycle multiply/divide unit (MDU) with HI/LO registers, an FSM sequencer and a pipeline stall output. It sits between the main control unit and the EX stage; the datapath reads mf_data for mfhi/mflo.

Parameters:
WIDTH, 32, operand and HI/LO width (>=4)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
ALUOp  input  3  operation class from main control
funct  input  6  R-type function field
issue  input  1  instruction in EX is valid this cycle
rs_data  input  WIDTH  operand A / dividend
rt_data  input  WIDTH  operand B / divisor
ALU_control  output  4  ALU operation select (combinational)
stall  output  1  hold pipeline (combinational)
md_busy  output  1  MDU computing
md_done  output  1  one-cycle pulse: HI/LO just written
mf_data  output  WIDTH  HI when funct=010000, else LO (combinational)

Behaviour:
- Decode is combinational, first match wins:
  - ALUOp=100 -> 0001.
  - ALUOp=000 -> 0010.
  - ALUOp=001 -> 0110.
  - Otherwise by funct:
    - 100000/100001 -> 0010
    - 100100 -> 0000
    - 100111 -> 1100
    - 100101 -> 0001
    - 100110 -> 1101 (xor, new)
    - 101010 -> 0111
    - 101011 -> 0011
    - all others -> 0110
  - ALU_control is independent of FSM state.
- MDU functs, valid only with ALUOp=010:
  - mult 011000, multu 011001, div 011010, divu 011011.
  - mfhi 010000, mflo 010010.
- FSM states IDLE, CALC, FIX.
  - IDLE -> CALC when issue & MDU op & !stall. Operands are latched, counter cleared, md_busy=1 from the next cycle.
  - CALC: exactly WIDTH cycles, one bit per cycle (shift-add multiply, restoring divide) on magnitudes. Counter counts 0..WIDTH-1, then -> FIX.
  - FIX: one cycle. Applies sign correction, writes HI/LO at the exit edge, -> IDLE.
  - md_done is high for the one cycle after that edge; md_busy is low from the same edge.
  - Total: issue edge to HI/LO valid = WIDTH+1 cycles.
- Signed rules (mult/div); unsigned ops ignore sign:
  - Product sign = xor of operand signs.
  - Quotient sign = xor of operand signs.
  - Remainder takes the dividend's sign.
  - Most-negative / -1 gives quotient = most-negative, remainder = 0.
- Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
- Divide: LO = quotient, HI = remainder.
- Divide by zero (signed or unsigned): LO = all ones, HI = rs_data unchanged. The FSM still runs the full WIDTH+1 cycles.
- stall = issue & ALUOp==010 & (MDU op | mfhi | mflo) & state!=IDLE.
  - stall is low in the md_done cycle, so mflo issued then reads the new LO.
  - MDU ops issued while stalled are not accepted; the pipeline reissues them.
- A non-MDU instruction issued while busy does not stall and does not disturb the MDU.
- Reset, asynchronous, including mid-operation:
  - state=IDLE, counter=0, HI=LO=0, latched operands=0.
  - md_busy=0, md_done=0, stall=0; the in-flight operation is discarded.

Test Plan:
- Decode sweep: ALUOp=010, funct=101010 -> 0111; funct=100110 -> 1101; funct=000000 -> 0110; ALUOp=100 with any funct -> 0001; ALUOp=001 -> 0110.
- mult, rs=FFFFFFFD (-3), rt=00000007 -> md_busy 33 cycles, then md_done single pulse; HI=FFFFFFFF, LO=FFFFFFEB. multu with the same operands -> HI=00000006, LO=FFFFFFEB.
- divu 100/7 -> LO=0000000E, HI=00000002. div rs=FFFFFFF9 (-7), rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF. div 80000000/FFFFFFFF -> LO=80000000, HI=0.
- div rs=5, rt=0 -> after 33 cycles LO=FFFFFFFF, HI=00000005.
- mflo issued 3 cycles after mult -> stall=1 each cycle until the md_done cycle, then stall=0 and mf_data equals the new LO. An add issued while busy -> stall=0, ALU_control=0010.
- Assert rst during cycle 10 of CALC -> md_busy=0, HI=LO=0 immediately, with no md_done pulse. A subsequent mult completes correctly.

Source files
------------

// File: rtl/alu_control_mdu.sv
// ALU control decoder with a multi-cycle multiply/divide unit.
// Decodes ALUOp/funct into the 4-bit ALU select. Sequences mult/multu/div/divu
// over WIDTH bit-serial CALC cycles plus one FIX cycle, which applies the sign.
// Owns the HI/LO registers, read through mf_data, and produces the pipeline stall.
// CNT_W must satisfy 2**CNT_W > WIDTH so that the counter can reach WIDTH-1.
module alu_control_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic             issue,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [3:0]       ALU_control,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] mf_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    // acc_hi: partial product high half / partial remainder
    // acc_lo: multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   mag_q, mag_d;        // |multiplicand| or |divisor|
    logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;  // raw dividend for divide-by-zero
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               done_q, done_d;

    logic               is_md_op_s;
    logic               is_mf_s;
    logic               start_s;
    logic               op_signed_s;
    logic               rs_neg_s;
    logic               rt_neg_s;
    logic [WIDTH-1:0]   rs_mag_s;
    logic [WIDTH-1:0]   rt_mag_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_neg_s;

    // Two's complement negation helper
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = (~v) + ONE_W;
    endfunction

    assign is_md_op_s  = (ALUOp == 3'b010) && (funct[5:2] == 4'b0110);
    assign is_mf_s     = (ALUOp == 3'b010) && ((funct == 6'b010000) || (funct == 6'b010010));
    assign start_s     = issue && is_md_op_s && (state_q == ST_IDLE);
    assign op_signed_s = (funct[0] == 1'b0);
    assign rs_neg_s    = op_signed_s && rs_data[WIDTH-1];
    assign rt_neg_s    = op_signed_s && rt_data[WIDTH-1];
    assign rs_mag_s    = rs_neg_s ? neg_w(rs_data) : rs_data;
    assign rt_mag_s    = rt_neg_s ? neg_w(rt_data) : rt_data;

    // Bit-serial datapath terms: shift-add multiply and restoring divide
    assign mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_trial_s = div_shift_s - {1'b0, mag_q};
    assign prod_s      = {acc_hi_q, acc_lo_q};
    assign prod_neg_s  = (~prod_s) + {{(2*WIDTH-1){1'b0}}, 1'b1};

    assign stall   = issue && (is_md_op_s || is_mf_s) && (state_q != ST_IDLE);
    assign md_busy = (state_q != ST_IDLE);
    assign md_done = done_q;
    assign mf_data = (funct == 6'b010000) ? hi_q : lo_q;

    // ALU operation select, independent of the MDU state
    always_comb begin
        ALU_control = 4'b0110;
        if (ALUOp == 3'b100) begin
            ALU_control = 4'b0001;
        end else if (ALUOp == 3'b000) begin
            ALU_control = 4'b0010;
        end else if (ALUOp == 3'b001) begin
            ALU_control = 4'b0110;
        end else begin
            case (funct)
                6'b100000, 6'b100001: ALU_control = 4'b0010;
                6'b100100:            ALU_control = 4'b0000;
                6'b100111:            ALU_control = 4'b1100;
                6'b100101:            ALU_control = 4'b0001;
                6'b100110:            ALU_control = 4'b1101;
                6'b101010:            ALU_control = 4'b0111;
                6'b101011:            ALU_control = 4'b0011;
                default:              ALU_control = 4'b0110;
            endcase
        end
    end

    // MDU sequencer: operand capture, iteration and sign fix-up
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        mag_d     = mag_q;
        rs_raw_d  = rs_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d   = ST_CALC;
                    cnt_d     = {CNT_W{1'b0}};
                    acc_hi_d  = {WIDTH{1'b0}};
                    acc_lo_d  = rs_mag_s;
                    mag_d     = rt_mag_s;
                    rs_raw_d  = rs_data;
                    is_div_d  = funct[1];
                    neg_res_d = rs_neg_s ^ rt_neg_s;
                    neg_rem_d = rs_neg_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    if (!div_trial_s[WIDTH]) begin
                        acc_hi_d = div_trial_s[WIDTH-1:0];
                    end else begin
                        acc_hi_d = div_shift_s[WIDTH-1:0];
                    end
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_trial_s[WIDTH]};
                end else begin
                    acc_hi_d = mul_sum_s[WIDTH:1];
                    acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    if (mag_q == {WIDTH{1'b0}}) begin
                        lo_d = {WIDTH{1'b1}};
                        hi_d = rs_raw_q;
                    end else begin
                        lo_d = neg_res_q ? neg_w(acc_lo_q) : acc_lo_q;
                        hi_d = neg_rem_q ? neg_w(acc_hi_q) : acc_hi_q;
                    end
                end else begin
                    if (neg_res_q) begin
                        {hi_d, lo_d} = prod_neg_s;
                    end else begin
                        {hi_d, lo_d} = prod_s;
                    end
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            acc_hi_q  <= {WIDTH{1'b0}};
            acc_lo_q  <= {WIDTH{1'b0}};
            mag_q     <= {WIDTH{1'b0}};
            rs_raw_q  <= {WIDTH{1'b0}};
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            mag_q     <= mag_d;
            rs_raw_q  <= rs_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
        end
    end

endmodule
